fetch_queue: RTL and testbench

//  Instruction prefetch stage between the PC/instruction-memory front end and the IF/ID buffer.
//  - Owns the fetch PC and issues sequential reads to the clocked instruction memory.
//  - Buffers returned instructions, each tagged with its PC, in a small ring queue.
//  - Presents them to decode under a valid/ready handshake.
//  - On a taken branch/jump redirect from the EX/WB branch logic: flushes queued and in-flight fetches, restarts at the target.

---
 rtl/fetch_queue_pkg.sv | 16 +
 rtl/fetch_queue_if.sv | 36 +++
 rtl/fetch_queue_ring.sv | 56 +++++
 rtl/fetch_queue.sv | 103 ++++++++++
 tb/tb_fetch_queue.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types and defaults for the instruction prefetch queue.
// Package fetch_pkg: widths, reset PC, NOP encoding, queue entry type.
package fetch_pkg;

    localparam int ADDR_W = 8;
    localparam int INSTR_W = 32;

    localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0] pc;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Instruction-memory and decode handshake bundle of the fetch queue.
// master = fetch queue side, slave = memory/decode side.
interface fetch_queue_if #(
    parameter int ADDR_W = fetch_pkg::ADDR_W,
    parameter int INSTR_W = fetch_pkg::INSTR_W
);

    logic imem_req_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [INSTR_W-1:0] imem_data_i;
    logic dec_valid_o;
    logic dec_ready_i;
    logic [INSTR_W-1:0] dec_instr_o;
    logic [ADDR_W-1:0] dec_pc_o;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input imem_data_i,
        output dec_valid_o,
        input dec_ready_i,
        output dec_instr_o,
        output dec_pc_o
    );

    modport slave (
        input imem_req_o,
        input imem_addr_o,
        output imem_data_i,
        input dec_valid_o,
        output dec_ready_i,
        input dec_instr_o,
        input dec_pc_o
    );

endinterface

// File: rtl/fetch_queue_ring.sv
// Ring buffer for fetched {instr, pc} entries with synchronous flush.
// Pointers wrap naturally; DEPTH must be a power of two.
module fq_ring
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W = INSTR_W + ADDR_W,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input logic clk,
    input logic rst_n,
    input logic push,
    input logic pop,
    input logic flush,
    input logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic [CW-1:0] count
);

    logic [W-1:0] mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    // Storage, pointers and occupancy; flush wins over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            head <= '0;
            tail <= '0;
            count <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[tail] <= wdata;
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign rdata = mem[head];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, buffers tagged words.
// Optional FETCH_QUEUE_STATS_EN adds starvation and flush counters.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int ADDR_W = fetch_pkg::ADDR_W,
    parameter int INSTR_W = fetch_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = fetch_pkg::RESET_PC,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input logic clk,
    input logic rst_n,
    input logic redirect_i,
    input logic [ADDR_W-1:0] redirect_pc_i,
    fetch_queue_if.master bus,
    output logic [CW-1:0] count_o
`ifdef FETCH_QUEUE_STATS_EN
    ,
    output logic [15:0] starve_cnt_o,
    output logic [15:0] flush_cnt_o
`endif
);

    import fetch_pkg::*;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] tag;
    logic inflight;
    logic fetchEn;
    logic req;
    logic push;
    logic pop;
    logic decValid;
    logic [CW:0] occ;
    logic [CW-1:0] count;
    logic [INSTR_W+ADDR_W-1:0] rdata;

    // Credit counts the in-flight word; a same-cycle pop is ignored.
    assign occ = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign req = fetchEn && !redirect_i && (occ < (CW+1)'(DEPTH));
    assign push = inflight && !redirect_i;
    assign decValid = (count != '0) && !redirect_i;
    assign pop = decValid && bus.dec_ready_i;

    assign bus.imem_req_o = req;
    assign bus.imem_addr_o = pc;
    assign bus.dec_valid_o = decValid;
    assign bus.dec_instr_o = rdata[INSTR_W+ADDR_W-1:ADDR_W];
    assign bus.dec_pc_o = rdata[ADDR_W-1:0];
    assign count_o = count;

    // Fetch PC, one-cycle start gate after reset, in-flight tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
            tag <= '0;
            inflight <= 1'b0;
            fetchEn <= 1'b0;
        end else begin
            fetchEn <= 1'b1;
            inflight <= req;
            if (req) begin
                tag <= pc;
            end
            if (redirect_i) begin
                pc <= redirect_pc_i;
            end else if (req) begin
                pc <= pc + 1'b1;
            end
        end
    end

    fq_ring #(
        .DEPTH(DEPTH),
        .W(INSTR_W + ADDR_W)
    ) uRing (
        .clk(clk),
        .rst_n(rst_n),
        .push(push),
        .pop(pop),
        .flush(redirect_i),
        .wdata({bus.imem_data_i, tag}),
        .rdata(rdata),
        .count(count)
    );

`ifdef FETCH_QUEUE_STATS_EN
    // Saturating counters for decode starvation and redirect flushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (bus.dec_ready_i && !decValid && (starve_cnt_o != '1)) begin
                starve_cnt_o <= starve_cnt_o + 1'b1;
            end
            if (redirect_i && (flush_cnt_o != '1)) begin
                flush_cnt_o <= flush_cnt_o + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed redirect/stall scenarios.
// Build with FETCH_QUEUE_STATS_EN to also exercise the stats counters.
module tb_fetch_queue;

    import fetch_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic redirect = 1'b0;
    logic [7:0] redirectPc = 8'h00;
    logic [2:0] count;
    logic [31:0] imemData = 32'h0;
`ifdef FETCH_QUEUE_STATS_EN
    logic [15:0] starveCnt;
    logic [15:0] flushCnt;
`endif

    int checks = 0;
    int errors = 0;
    fq_entry_t expQ[$];

    fetch_queue_if bus ();

    fetch_queue dut (
        .clk(clk),
        .rst_n(rst_n),
        .redirect_i(redirect),
        .redirect_pc_i(redirectPc),
        .bus(bus),
        .count_o(count)
`ifdef FETCH_QUEUE_STATS_EN
        ,
        .starve_cnt_o(starveCnt),
        .flush_cnt_o(flushCnt)
`endif
    );

    always #5 clk = ~clk;

    // Clocked instruction memory: word at addr is addr + 0x100.
    always @(posedge clk) begin
        if (bus.imem_req_o) begin
            imemData <= 32'h100 + {24'h0, bus.imem_addr_o};
        end
    end
    assign bus.imem_data_i = imemData;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_pcs(input logic [7:0] first, input int n);
        fq_entry_t e;
        logic [7:0] p;
        p = first;
        for (int i = 0; i < n; i++) begin
            e.pc = p;
            e.instr = 32'h100 + {24'h0, p};
            expQ.push_back(e);
            p = p + 8'h1;
        end
    endtask

    task automatic wait_drain(input string name, input int maxCyc);
        int i;
        for (i = 0; i < maxCyc; i++) begin
            @(posedge clk);
            #1;
            if (expQ.size() == 0) break;
        end
        if (i == maxCyc) begin
            checks++;
            errors++;
            $display("FAIL %s: drain timeout, %0d left, expected 0",
                     name, expQ.size());
            expQ.delete();
        end
    endtask

    // Monitor: every accepted beat is compared against the scoreboard.
    always @(negedge clk) begin
        fq_entry_t e;
        if (rst_n && bus.dec_valid_o && bus.dec_ready_i) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got pc %0h expected none",
                         bus.dec_pc_o);
            end else begin
                e = expQ.pop_front();
                chk("pop_pc", 32'(bus.dec_pc_o), 32'(e.pc));
                chk("pop_instr", bus.dec_instr_o, e.instr);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        bus.dec_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (8) @(posedge clk);

        // Test 1: reset mid-run, then restart from RESET_PC.
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(bus.dec_valid_o), 32'd0);
        chk("rst_req", 32'(bus.imem_req_o), 32'd0);
        chk("rst_instr", bus.dec_instr_o, 32'h0);
        chk("rst_pc", 32'(bus.dec_pc_o), 32'h0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("c1_req", 32'(bus.imem_req_o), 32'd1);
        chk("c1_addr", 32'(bus.imem_addr_o), 32'h00);
        chk("c1_valid", 32'(bus.dec_valid_o), 32'd0);
        @(posedge clk);
        #1;
        chk("c2_valid", 32'(bus.dec_valid_o), 32'd0);
        chk("c2_addr", 32'(bus.imem_addr_o), 32'h01);
        @(posedge clk);
        #1;
        chk("c3_valid", 32'(bus.dec_valid_o), 32'd1);
        chk("c3_pc", 32'(bus.dec_pc_o), 32'h00);
        chk("c3_instr", bus.dec_instr_o, 32'h100);

        // Test 2: decode stalls for 10 cycles, queue fills, then drains.
        repeat (10) @(posedge clk);
        #1;
        chk("stall_count", 32'(count), 32'd4);
        chk("stall_req", 32'(bus.imem_req_o), 32'd0);
        chk("stall_pc", 32'(bus.dec_pc_o), 32'h00);
        chk("stall_instr", bus.dec_instr_o, 32'h100);
        expect_pcs(8'h00, 10);
        bus.dec_ready_i = 1'b1;
        wait_drain("drain1", 40);
        bus.dec_ready_i = 1'b0;

        // Test 3: redirect with 3 queued and one in flight.
        for (n = 0; n < 20; n++) begin
            if (count == 3'd3 && !bus.imem_req_o) break;
            @(posedge clk);
            #1;
        end
        chk("pre_redirect_count", 32'(count), 32'd3);
        redirect = 1'b1;
        redirectPc = 8'h08;
        expQ.delete();
        expect_pcs(8'h08, 4);
        #1;
        chk("t0_req", 32'(bus.imem_req_o), 32'd0);
        chk("t0_valid", 32'(bus.dec_valid_o), 32'd0);
        @(posedge clk);
        #1;
        redirect = 1'b0;
        #1;
        chk("t1_count", 32'(count), 32'd0);
        chk("t1_req", 32'(bus.imem_req_o), 32'd1);
        chk("t1_addr", 32'(bus.imem_addr_o), 32'h08);
        chk("t1_valid", 32'(bus.dec_valid_o), 32'd0);
        @(posedge clk);
        #1;
        chk("t2_valid", 32'(bus.dec_valid_o), 32'd0);
        @(posedge clk);
        #1;
        chk("t3_valid", 32'(bus.dec_valid_o), 32'd1);
        chk("t3_pc", 32'(bus.dec_pc_o), 32'h08);
        bus.dec_ready_i = 1'b1;
        wait_drain("drain3", 30);
        bus.dec_ready_i = 1'b0;

        // Test 4: PC wrap 0xFE -> 0x01.
        redirect = 1'b1;
        redirectPc = 8'hFE;
        expQ.delete();
        expect_pcs(8'hFE, 4);
        @(posedge clk);
        #1;
        redirect = 1'b0;
        bus.dec_ready_i = 1'b1;
        wait_drain("drain4", 30);
        bus.dec_ready_i = 1'b0;

        // Test 5: back-to-back redirects, the last target wins.
        redirect = 1'b1;
        redirectPc = 8'h10;
        @(posedge clk);
        #1;
        redirectPc = 8'h20;
        expQ.delete();
        expect_pcs(8'h20, 3);
        #1;
        chk("t5_req", 32'(bus.imem_req_o), 32'd0);
        @(posedge clk);
        #1;
        redirect = 1'b0;
        #1;
        chk("t5_addr", 32'(bus.imem_addr_o), 32'h20);
        bus.dec_ready_i = 1'b1;
        wait_drain("drain5", 30);
        bus.dec_ready_i = 1'b0;

`ifdef FETCH_QUEUE_STATS_EN
        // Test 6: 5 starved cycles and 2 redirects after a fresh reset.
        @(negedge clk) rst_n = 1'b0;
        expQ.delete();
        #1;
        chk("stats_rst_starve", 32'(starveCnt), 32'd0);
        chk("stats_rst_flush", 32'(flushCnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.dec_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.dec_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        redirect = 1'b1;
        redirectPc = 8'h30;
        @(posedge clk);
        #1;
        redirect = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        redirect = 1'b1;
        redirectPc = 8'h40;
        @(posedge clk);
        #1;
        redirect = 1'b0;
        bus.dec_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.dec_ready_i = 1'b0;
        chk("stats_starve", 32'(starveCnt), 32'd5);
        chk("stats_flush", 32'(flushCnt), 32'd2);
`endif

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
